eth_rx_pkt_queue: RTL and testbench
===================================

// Module: eth_rx_pkt_queue
// PURPOSE
//  Per-port store-and-forward ingress packet queue between the port receiver and eth_tx.
//  Stores words as {end, start, data[31:0]} and exposes them first-word-fall-through on rd_data/rd_en/empty/full.
//  empty stays high until at least one complete packet is committed, so the transmitter never starts a partial packet.
//  Packets that overflow or are malformed are discarded whole and counted.
// PARAMETERS
//  DEPTH  64  entries; power of 2, >= 4
//  AW     $clog2(DEPTH)  address width; pointers are AW+1 bits
//  CNT_W  16  drop counter width
// PORTS
//  clk        in   1       clock
//  rstn       in   1       reset, asynchronous, active-low
//  wr_en      in   1       wr_data valid this cycle
//  wr_data    in   34      {end[33], start[32], data[31:0]} from receiver
//  rd_en      in   1       pop head word (from eth_tx)
//  rd_data    out  34      head word, FWFT; 0 when empty
//  empty      out  1       no committed word available
//  full       out  1       (wr_ptr - rd_ptr) == DEPTH
//  pkt_count  out  AW+1    committed packets held, not yet fully read
//  drop_count out  CNT_W   packets discarded, saturating
//  overflow   out  1       1-cycle pulse when a packet is dropped for lack of space
// BEHAVIOUR
//  Reset: wr_ptr = cm_ptr = rd_ptr = 0, state W_IDLE, pkt_count = drop_count = 0, overflow = 0.
//   Resulting outputs: empty = 1, full = 0, rd_data = 0. Reset mid-packet or mid-read discards all contents.
//  Pointers: wr_ptr is the speculative write pointer, cm_ptr the commit pointer, rd_ptr the read pointer.
//   Arithmetic is mod 2^(AW+1). Memory is indexed by ptr[AW-1:0].
//   empty = (rd_ptr == cm_ptr); rd_data = mem[rd_ptr] when !empty.
//  Read: rd_en & !empty -> rd_ptr++ at the edge. rd_en while empty is ignored.
//  full and the accept decision use pre-edge pointers. A write arriving while full is an overflow even if rd_en pops in the same cycle.
//  "write" = mem[wr_ptr] <= wr_data; wr_ptr++.
//  "commit" = cm_ptr <= wr_ptr + 1 in the same edge as the write of the end word.
//   empty falls the cycle after the edge that writes the end word (1-cycle latency).
//  Write FSM:
//   W_IDLE:
//    wr_en & start & !full: write. end=1 -> commit, stay W_IDLE; end=0 -> W_PKT.
//    wr_en & start & full: drop_count++, overflow=1. end=1 -> stay W_IDLE; end=0 -> W_DROP.
//    wr_en & !start: stray word, ignored, not counted.
//   W_PKT:
//    wr_en & !start & !full: write. end=1 -> commit, W_IDLE.
//    wr_en & !start & full: wr_ptr <= cm_ptr, drop_count++, overflow=1. end=1 -> W_IDLE; end=0 -> W_DROP.
//    wr_en & start: partial packet discarded (drop_count++). The new word is handled as in W_IDLE with wr_ptr = cm_ptr.
//   W_DROP:
//    wr_en & !start: discard; end=1 -> W_IDLE.
//    wr_en & start: handled as in W_IDLE (new packet).
//  A packet longer than DEPTH always overflows and is dropped. Committed words are never overwritten.
//  pkt_count: +1 on commit; -1 on a pop of a word with end=1; unchanged when both occur in one cycle.
//  drop_count saturates at 2^CNT_W-1.
//  overflow is registered, high for exactly one cycle per overflow-dropped packet.
// TESTING
//  T1 After reset, write 3-word pkt {S,0x1},{0xA5A5A5A5},{E,0x3}: empty=1 until the cycle after the E write.
//     Reads return 0x1_00000001, 0x0_A5A5A5A5, 0x2_00000003; pkt_count goes 1 -> 0; empty=1 after.
//  T2 Single-word pkt with start=end=1, data 0xDEADBEEF: rd_data=0x3_DEADBEEF the next cycle, pkt_count=1; pop -> empty.
//  T3 DEPTH=8, no reads, write a 10-word pkt: full after 8 writes; overflow pulses once; drop_count=1; empty stays 1.
//     A following 2-word pkt is accepted and read back intact.
//  T4 Write 3 words without end, then a new 2-word pkt starting 0x2: only the 2-word pkt is read out; drop_count=1.
//  T5 Continuous back-to-back writes and reads of 2..7-word pkts over 3*DEPTH words (wrap):
//     reads match the scoreboard; no full while reads keep pace; pkt_count never exceeds the true count.
//  T6 Assert rstn low mid-write and mid-read: next cycle empty=1, full=0, pkt_count=0, drop_count=0; the next pkt is stored correctly.

Source files
------------

// File: rtl/eth_rx_pkt_queue.sv
// Store-and-forward ingress packet queue: words become visible on the FWFT read side only
// once their packet's end word is committed; overflowing or truncated packets are dropped whole.
module eth_rx_pkt_queue #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH),
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [33:0]      wr_data,
  input  logic             rd_en,
  output logic [33:0]      rd_data,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      pkt_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             overflow
);

  typedef enum logic [1:0] {W_IDLE, W_PKT, W_DROP} w_state_e;

  localparam logic [AW:0]    LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [CNT_W:0] LP_SAT   = {1'b0, {CNT_W{1'b1}}};

  w_state_e         r_state, w_state_nxt;
  logic [AW:0]      r_wr_ptr, r_cm_ptr, r_rd_ptr;
  logic [AW:0]      r_pkt_count;
  logic [CNT_W-1:0] r_drop_count;
  logic             r_overflow;
  logic [33:0]      r_mem [DEPTH];

  logic        w_start, w_end, w_pop, w_pop_end, w_empty;
  logic [AW:0] w_base, w_occ_base, w_occ;
  logic        w_base_full, w_accepting;
  logic        w_wr, w_commit, w_ovf, w_partial;
  logic [1:0]  w_drop_inc;
  logic [CNT_W:0] w_drop_sum;

  assign w_start = wr_data[32];
  assign w_end   = wr_data[33];

  // A start word arriving mid-packet restarts from the commit pointer, so the discarded
  // partial packet's space is reclaimed before the full test is made.
  assign w_base      = (r_state == W_PKT && w_start) ? r_cm_ptr : r_wr_ptr;
  assign w_occ_base  = w_base - r_rd_ptr;
  assign w_base_full = (w_occ_base == LP_DEPTH);
  assign w_occ       = r_wr_ptr - r_rd_ptr;

  assign w_empty   = (r_rd_ptr == r_cm_ptr);
  assign w_pop     = rd_en && !w_empty;
  assign w_pop_end = w_pop && r_mem[r_rd_ptr[AW-1:0]][33];

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= W_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (wr_en) begin
      if (w_start) begin
        w_state_nxt = w_end ? W_IDLE : (w_base_full ? W_DROP : W_PKT);
      end else begin
        case (r_state)
          W_PKT:   w_state_nxt = w_end ? W_IDLE : (w_base_full ? W_DROP : W_PKT);
          W_DROP:  w_state_nxt = w_end ? W_IDLE : W_DROP;
          default: w_state_nxt = r_state;
        endcase
      end
    end
  end

  // Output decode: write/commit/drop strobes for the datapath
  always_comb begin
    w_wr        = 1'b0;
    w_commit    = 1'b0;
    w_ovf       = 1'b0;
    w_partial   = 1'b0;
    w_accepting = wr_en && (w_start || r_state == W_PKT);
    if (wr_en && w_start && r_state == W_PKT) w_partial = 1'b1;
    if (w_accepting) begin
      if (w_base_full) begin
        w_ovf = 1'b1;
      end else begin
        w_wr     = 1'b1;
        w_commit = w_end;
      end
    end
    w_drop_inc = {1'b0, w_partial} + {1'b0, w_ovf};
  end

  assign w_drop_sum = {1'b0, r_drop_count} + (CNT_W+1)'(w_drop_inc);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr     <= '0;
      r_cm_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_pkt_count  <= '0;
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_wr)       r_wr_ptr <= w_base + 1'b1;
      else if (w_ovf) r_wr_ptr <= r_cm_ptr;
      if (w_commit)   r_cm_ptr <= w_base + 1'b1;
      if (w_pop)      r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_commit, w_pop_end})
        2'b10:   r_pkt_count <= r_pkt_count + 1'b1;
        2'b01:   r_pkt_count <= r_pkt_count - 1'b1;
        default: r_pkt_count <= r_pkt_count;
      endcase
      r_drop_count <= (w_drop_sum > LP_SAT) ? LP_SAT[CNT_W-1:0] : w_drop_sum[CNT_W-1:0];
      r_overflow   <= w_ovf;
    end
  end

  // NOTE: the storage array has no reset; pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[w_base[AW-1:0]] <= wr_data;
  end

  assign rd_data    = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign empty      = w_empty;
  assign full       = (w_occ == LP_DEPTH);
  assign pkt_count  = r_pkt_count;
  assign drop_count = r_drop_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_eth_rx_pkt_queue.sv
// Directed bench for eth_rx_pkt_queue at DEPTH=8: commit latency, FWFT reads, overflow,
// truncated packets, wrap-around streaming against a scoreboard, and asynchronous reset.
module tb_eth_rx_pkt_queue;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             wr_en = 1'b0;
  logic [33:0]      wr_data = '0;
  logic             rd_en = 1'b0;
  logic [33:0]      rd_data;
  logic             empty, full, overflow;
  logic [AW:0]      pkt_count;
  logic [CNT_W-1:0] drop_count;

  eth_rx_pkt_queue #(.DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .pkt_count(pkt_count),
    .drop_count(drop_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [33:0] sb [$];
  int          model_pkts = 0;
  bit          t5_on = 1'b0;
  bit          pop_end = 1'b0;
  int          n_read = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [33:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    tick();
    wr_en   = 1'b0;
    wr_data = '0;
  endtask

  task automatic rd();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  // Packet-count model for the streaming phase, built from bench-driven inputs only
  always @(posedge clk) begin
    if (t5_on) begin
      if (wr_en && wr_data[33]) model_pkts++;
      if (rd_en && pop_end)     model_pkts--;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) tick();
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_overflow", overflow, 0);
    rstn = 1'b1;
    tick();

    // T1: three-word packet, visible only after the end word
    wr(34'h1_00000001);
    check("t1_empty_w1", empty, 1);
    wr(34'h0_A5A5A5A5);
    check("t1_empty_w2", empty, 1);
    wr(34'h2_00000003);
    check("t1_empty_after_end", empty, 0);
    check("t1_pkt_count", pkt_count, 1);
    check("t1_rd0", rd_data, 34'h1_00000001);
    rd();
    check("t1_rd1", rd_data, 34'h0_A5A5A5A5);
    rd();
    check("t1_rd2", rd_data, 34'h2_00000003);
    check("t1_pkt_count_last", pkt_count, 1);
    rd();
    check("t1_empty_done", empty, 1);
    check("t1_pkt_count_done", pkt_count, 0);
    check("t1_rd_data_empty", rd_data, 0);
    rd();
    check("t1_rd_when_empty", empty, 1);

    // T2: single-word packet
    wr(34'h3_DEADBEEF);
    check("t2_rd", rd_data, 34'h3_DEADBEEF);
    check("t2_pkt_count", pkt_count, 1);
    rd();
    check("t2_empty", empty, 1);
    check("t2_pkt_count_done", pkt_count, 0);

    // T3: 10-word packet into an 8-entry queue, then a normal packet
    for (int i = 0; i < 10; i++) begin
      wr({(i == 9), (i == 0), 32'h3000_0000 + 32'(i)});
      if (i == 7) check("t3_full", full, 1);
      if (i == 8) begin
        check("t3_overflow_pulse", overflow, 1);
        check("t3_drop_count", drop_count, 1);
        check("t3_full_released", full, 0);
      end
      if (i == 9) check("t3_overflow_single", overflow, 0);
      check($sformatf("t3_empty_%0d", i), empty, 1);
    end
    check("t3_pkt_count", pkt_count, 0);
    wr(34'h1_00000B01);
    wr(34'h2_00000B02);
    check("t3_next_rd0", rd_data, 34'h1_00000B01);
    rd();
    check("t3_next_rd1", rd_data, 34'h2_00000B02);
    rd();
    check("t3_next_empty", empty, 1);

    // T4: truncated packet followed by a new start; stray word in idle
    wr(34'h1_000000C1);
    wr(34'h0_000000C2);
    wr(34'h0_000000C3);
    wr(34'h1_00000002);
    check("t4_drop_count", drop_count, 2);
    check("t4_no_overflow", overflow, 0);
    check("t4_empty_mid", empty, 1);
    wr(34'h2_00000D02);
    check("t4_rd0", rd_data, 34'h1_00000002);
    check("t4_pkt_count", pkt_count, 1);
    rd();
    check("t4_rd1", rd_data, 34'h2_00000D02);
    rd();
    check("t4_empty", empty, 1);
    wr(34'h0_00000077);
    check("t4_stray_drop_count", drop_count, 2);
    check("t4_stray_empty", empty, 1);

    // T5: back-to-back 2..7-word packets with concurrent reads (27 words, wraps 3x)
    model_pkts = 0;
    n_read     = 0;
    t5_on      = 1'b1;
    fork
      begin
        for (int p = 0; p < 6; p++) begin
          for (int j = 0; j < p + 2; j++) begin
            logic [33:0] w;
            w = {(j == p + 1), (j == 0), 32'h5000_0000 | (32'(p) << 8) | 32'(j)};
            sb.push_back(w);
            wr(w);
          end
        end
      end
      begin
        for (int cyc = 0; cyc < 300 && n_read < 27; cyc++) begin
          @(posedge clk);
          #1;
          check("t5_no_full", full, 0);
          check("t5_pkt_count", pkt_count, 64'(model_pkts));
          if (!empty) begin
            check("t5_sb_nonempty", 64'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
              check($sformatf("t5_rd_%0d", n_read), rd_data, sb[0]);
              pop_end = sb[0][33];
              void'(sb.pop_front());
            end
            rd_en = 1'b1;
            n_read++;
          end else begin
            rd_en = 1'b0;
          end
        end
        tick();
        rd_en = 1'b0;
      end
    join
    t5_on = 1'b0;
    check("t5_words_read", 64'(n_read), 27);
    check("t5_empty_done", empty, 1);
    check("t5_pkt_count_done", pkt_count, 0);
    check("t5_drop_unchanged", drop_count, 2);

    // T6: asynchronous reset mid-write, then mid-read
    wr(34'h1_000000E1);
    wr_en   = 1'b1;
    wr_data = 34'h0_000000E2;
    #2;
    rstn = 1'b0;
    #1;
    check("t6w_empty", empty, 1);
    check("t6w_full", full, 0);
    check("t6w_pkt_count", pkt_count, 0);
    check("t6w_drop_count", drop_count, 0);
    wr_en   = 1'b0;
    wr_data = '0;
    tick();
    rstn = 1'b1;
    tick();
    check("t6w_empty_after", empty, 1);
    wr(34'h1_000000F1);
    wr(34'h2_000000F2);
    rd();
    check("t6r_before_rst", rd_data, 34'h2_000000F2);
    rd_en = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    check("t6r_empty", empty, 1);
    check("t6r_pkt_count", pkt_count, 0);
    check("t6r_rd_data", rd_data, 0);
    rd_en = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    wr(34'h3_12345678);
    check("t6_next_rd", rd_data, 34'h3_12345678);
    check("t6_next_pkt_count", pkt_count, 1);
    rd();
    check("t6_next_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
